rd_burst_scheduler: RTL and testbench

- Read-phase sequencer of the memory checker.
- Splits a configured read region into AMM read bursts and issues them on the AMM master port.
- Pushes one compare descriptor per accepted burst into the compare block's descriptor FIFO.
- Throttles issue with descriptor and word credits so the compare block's descriptor FIFO and read-data FIFO never overflow; aborts cleanly on compare error.

---
 rtl/rd_burst_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_rd_burst_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_scheduler.sv
// rtl/rd_burst_scheduler.sv - read-phase burst sequencer with descriptor/word credit throttling
module rd_burst_scheduler #(
   parameter int ADDR_W          = 32,
   parameter int BURST_W         = 11,
   parameter int CMP_FIFO_DEPTH  = 4,
   parameter int DATA_FIFO_DEPTH = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_test_i,
   input  logic [ADDR_W-1:0]  cfg_start_addr_i,
   input  logic [31:0]        cfg_words_total_i,
   input  logic [BURST_W-1:0] cfg_burst_len_i,
   input  logic [7:0]         cfg_data_ptrn_i,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic [BURST_W-1:0] burstcount_o,
   input  logic               waitrequest_i,
   input  logic               readdatavalid_i,
   output logic               cmp_en_o,
   output logic [ADDR_W-1:0]  cmp_start_addr_o,
   output logic [BURST_W-2:0] cmp_words_count_o,
   output logic [7:0]         cmp_data_ptrn_o,
   input  logic               cmp_rd_i,
   input  logic               cmp_error_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               abort_o
);

   localparam int DCNT_W = $clog2(CMP_FIFO_DEPTH + 1);
   localparam int WCNT_W = $clog2(DATA_FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE_S, CALC_S, WAIT_S, ISSUE_S, DRAIN_S, ABORT_S, DONE_S
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [31:0]         words_left;
   logic [BURST_W-1:0]  burst_max;
   logic [BURST_W-1:0]  burst;
   logic [BURST_W-1:0]  burst_calc;
   logic [7:0]          ptrn;
   logic                err_pend;
   logic [DCNT_W-1:0]   desc_cnt;
   logic [WCNT_W-1:0]   word_cnt;
   logic                accept;
   logic                desc_dec;
   logic                word_dec;
   logic                credit_calc;
   logic                credit_burst;

   // A zero length means single-word bursts; anything larger than the data FIFO
   // could never gain word credit, so it is capped at the FIFO depth.
   function automatic logic [BURST_W-1:0] clamp_len(input logic [BURST_W-1:0] len);
      if (len == '0) begin
         return BURST_W'(1);
      end
      if (32'(len) > 32'(DATA_FIFO_DEPTH)) begin
         return BURST_W'(DATA_FIFO_DEPTH);
      end
      return len;
   endfunction

   assign accept     = read_o && !waitrequest_i;
   assign desc_dec   = cmp_rd_i && (desc_cnt != '0);
   assign word_dec   = readdatavalid_i && (word_cnt != '0);
   assign burst_calc = (words_left < 32'(burst_max)) ? words_left[BURST_W-1:0] : burst_max;

   // Credit check for a fresh burst size (CALC_S) and for the held burst (WAIT_S).
   always_comb begin
      credit_calc  = (32'(desc_cnt) < 32'(CMP_FIFO_DEPTH)) &&
                     ((32'(word_cnt) + 32'(burst_calc)) <= 32'(DATA_FIFO_DEPTH));
      credit_burst = (32'(desc_cnt) < 32'(CMP_FIFO_DEPTH)) &&
                     ((32'(word_cnt) + 32'(burst)) <= 32'(DATA_FIFO_DEPTH));
   end

   assign address_o         = addr_cnt;
   assign burstcount_o      = burst;
   assign cmp_en_o          = accept;
   assign cmp_start_addr_o  = accept ? addr_cnt : '0;
   assign cmp_words_count_o = accept ? (BURST_W-1)'(burst - BURST_W'(1)) : '0;
   assign cmp_data_ptrn_o   = accept ? ptrn : '0;

   // Outstanding descriptors and words held by the compare block's FIFOs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         desc_cnt <= '0;
         word_cnt <= '0;
      end else begin
         desc_cnt <= desc_cnt + DCNT_W'(accept) - DCNT_W'(desc_dec);
         word_cnt <= word_cnt + (accept ? WCNT_W'(burst) : '0) - WCNT_W'(word_dec);
      end
   end

   // Sequencer: split the region into bursts, throttle on credits, drain or abort.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE_S;
         addr_cnt   <= '0;
         words_left <= '0;
         burst_max  <= '0;
         burst      <= '0;
         ptrn       <= '0;
         err_pend   <= 1'b0;
         read_o     <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         abort_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE_S: begin
               if (start_test_i) begin
                  addr_cnt   <= cfg_start_addr_i;
                  words_left <= cfg_words_total_i;
                  burst_max  <= clamp_len(cfg_burst_len_i);
                  ptrn       <= cfg_data_ptrn_i;
                  err_pend   <= 1'b0;
                  abort_o    <= 1'b0;
                  if (cfg_words_total_i == '0) begin
                     state <= DONE_S;
                  end else begin
                     state  <= CALC_S;
                     busy_o <= 1'b1;
                  end
               end
            end
            CALC_S: begin
               if (cmp_error_i) begin
                  state <= ABORT_S;
               end else begin
                  burst <= burst_calc;
                  if (credit_calc) begin
                     state  <= ISSUE_S;
                     read_o <= 1'b1;
                  end else begin
                     state <= WAIT_S;
                  end
               end
            end
            WAIT_S: begin
               if (cmp_error_i) begin
                  state <= ABORT_S;
               end else if (credit_burst) begin
                  state  <= ISSUE_S;
                  read_o <= 1'b1;
               end
            end
            ISSUE_S: begin
               // An AMM request cannot be withdrawn, so an error only takes effect after accept.
               if (accept) begin
                  read_o     <= 1'b0;
                  addr_cnt   <= addr_cnt + ADDR_W'(burst);
                  words_left <= words_left - 32'(burst);
                  if (err_pend || cmp_error_i) begin
                     state <= ABORT_S;
                  end else if (words_left == 32'(burst)) begin
                     state <= DRAIN_S;
                  end else begin
                     state <= CALC_S;
                  end
               end else if (cmp_error_i) begin
                  err_pend <= 1'b1;
               end
            end
            DRAIN_S: begin
               if (cmp_error_i) begin
                  state <= ABORT_S;
               end else if ((word_cnt == '0) && (desc_cnt == '0)) begin
                  state <= DONE_S;
               end
            end
            ABORT_S: begin
               // The compare block stops popping after an error, so only data is awaited.
               if (word_cnt == '0) begin
                  abort_o <= 1'b1;
                  state   <= DONE_S;
               end
            end
            DONE_S: begin
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE_S;
            end
            default: begin
               state <= IDLE_S;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rd_burst_scheduler.sv
// tb/tb_rd_burst_scheduler.sv - directed vector bench for rd_burst_scheduler
module tb_rd_burst_scheduler;

   localparam int BIG = 1000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] cfg_addr = '0;
   logic [31:0] cfg_total = '0;
   logic [10:0] cfg_len = '0;
   logic [7:0]  cfg_ptrn = '0;
   logic [31:0] address;
   logic        read;
   logic [10:0] burstcount;
   logic        wr = 1'b0;
   logic        rdv = 1'b0;
   logic        cmp_en;
   logic [31:0] cmp_addr;
   logic [9:0]  cmp_wc;
   logic [7:0]  cmp_ptrn;
   logic        cmp_rd = 1'b0;
   logic        cmp_err = 1'b0;
   logic        busy;
   logic        done;
   logic        abort_f;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int start_cyc = 0;
   int first_read = -1;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_rdv_cyc = 0;
   int mem_pending = 0;
   int desc_q = 0;
   int rdv_given = 0;
   int pop_given = 0;
   int rdv_allow = BIG;
   int pop_allow = BIG;
   logic [31:0] rec_addr[$];
   logic [31:0] rec_caddr[$];
   logic [10:0] rec_len[$];
   logic [9:0]  rec_wc[$];
   logic [7:0]  rec_ptrn[$];

   typedef struct {
      logic [31:0]       addr;
      logic [31:0]       total;
      logic [10:0]       blen;
      logic [7:0]        ptrn;
      int                n;
      logic [5:0][31:0]  ea;
      logic [5:0][10:0]  el;
   } vec_t;

   vec_t vecs[6];

   rd_burst_scheduler dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_test_i      (start),
      .cfg_start_addr_i  (cfg_addr),
      .cfg_words_total_i (cfg_total),
      .cfg_burst_len_i   (cfg_len),
      .cfg_data_ptrn_i   (cfg_ptrn),
      .address_o         (address),
      .read_o            (read),
      .burstcount_o      (burstcount),
      .waitrequest_i     (wr),
      .readdatavalid_i   (rdv),
      .cmp_en_o          (cmp_en),
      .cmp_start_addr_o  (cmp_addr),
      .cmp_words_count_o (cmp_wc),
      .cmp_data_ptrn_o   (cmp_ptrn),
      .cmp_rd_i          (cmp_rd),
      .cmp_error_i       (cmp_err),
      .busy_o            (busy),
      .done_o            (done),
      .abort_o           (abort_f)
   );

   always #5 clk = ~clk;

   // Memory and compare-block responder plus transaction log, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            rec_addr.delete(); rec_caddr.delete(); rec_len.delete();
            rec_wc.delete(); rec_ptrn.delete();
            mem_pending = 0; desc_q = 0; rdv_given = 0; pop_given = 0;
            done_cnt = 0; first_read = -1;
            rdv = 1'b0; cmp_rd = 1'b0;
         end else begin
            if (read && first_read < 0) first_read = cyc;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            rdv = 1'b0;
            if (rdv_given < rdv_allow && mem_pending > 0) begin
               rdv = 1'b1; mem_pending--; rdv_given++; last_rdv_cyc = cyc;
            end
            cmp_rd = 1'b0;
            if (pop_given < pop_allow && desc_q > 0) begin
               cmp_rd = 1'b1; desc_q--; pop_given++;
            end
            if (cmp_en) begin
               rec_addr.push_back(address);
               rec_caddr.push_back(cmp_addr);
               rec_len.push_back(burstcount);
               rec_wc.push_back(cmp_wc);
               rec_ptrn.push_back(cmp_ptrn);
               mem_pending += int'(burstcount);
               desc_q++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; wr = 1'b0; cmp_err = 1'b0;
      rdv_allow = BIG; pop_allow = BIG;
      wait_cycles(3);
      rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] a, input logic [31:0] t,
                              input logic [10:0] l, input logic [7:0] p);
      @(posedge clk); #1;
      cfg_addr = a; cfg_total = t; cfg_len = l; cfg_ptrn = p;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(posedge clk); #1;
         if (done_cnt >= target) ok = 1'b1;
      end
      chk(name, ok, 1'b1);
   endtask

   task automatic setb(input int i, input int j, input logic [31:0] a, input logic [10:0] l);
      vecs[i].ea[j] = a;
      vecs[i].el[j] = l;
   endtask

   initial begin
      bit found;
      int d0;

      vecs[0] = '{addr:32'h100,      total:10,  blen:4,   ptrn:8'hA5, n:3, ea:'0, el:'0};
      vecs[1] = '{addr:32'h0,        total:5,   blen:0,   ptrn:8'h01, n:5, ea:'0, el:'0};
      vecs[2] = '{addr:32'hFFFFFFFE, total:6,   blen:4,   ptrn:8'h7E, n:2, ea:'0, el:'0};
      vecs[3] = '{addr:32'h40,       total:100, blen:200, ptrn:8'h99, n:2, ea:'0, el:'0};
      vecs[4] = '{addr:32'h10,       total:7,   blen:7,   ptrn:8'h42, n:1, ea:'0, el:'0};
      vecs[5] = '{addr:32'h300,      total:0,   blen:4,   ptrn:8'hEE, n:0, ea:'0, el:'0};
      setb(0, 0, 32'h100, 4); setb(0, 1, 32'h104, 4); setb(0, 2, 32'h108, 2);
      setb(1, 0, 32'h0, 1); setb(1, 1, 32'h1, 1); setb(1, 2, 32'h2, 1);
      setb(1, 3, 32'h3, 1); setb(1, 4, 32'h4, 1);
      setb(2, 0, 32'hFFFFFFFE, 4); setb(2, 1, 32'h2, 2);
      setb(3, 0, 32'h40, 64); setb(3, 1, 32'h80, 36);
      setb(4, 0, 32'h10, 7);

      do_reset();
      chk("rst_read", read, 1'b0);
      chk("rst_cmp_en", cmp_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_abort", abort_f, 1'b0);
      chk("rst_address", address, 32'h0);
      chk("rst_burstcount", burstcount, 11'h0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         pulse_start(vecs[i].addr, vecs[i].total, vecs[i].blen, vecs[i].ptrn);
         wait_done(1, 2000, $sformatf("v%0d_done_timeout", i));
         wait_cycles(5);
         chk($sformatf("v%0d_done_count", i), done_cnt, 1);
         chk($sformatf("v%0d_bursts", i), rec_addr.size(), vecs[i].n);
         for (int j = 0; j < vecs[i].n && j < rec_addr.size(); j++) begin
            chk($sformatf("v%0d_b%0d_addr", i, j), rec_addr[j], vecs[i].ea[j]);
            chk($sformatf("v%0d_b%0d_len", i, j), rec_len[j], vecs[i].el[j]);
            chk($sformatf("v%0d_b%0d_cmp_addr", i, j), rec_caddr[j], vecs[i].ea[j]);
            chk($sformatf("v%0d_b%0d_wc", i, j), rec_wc[j], vecs[i].el[j] - 11'd1);
            chk($sformatf("v%0d_b%0d_ptrn", i, j), rec_ptrn[j], vecs[i].ptrn);
         end
         if (vecs[i].total == 0) begin
            chk($sformatf("v%0d_done_latency", i), done_cyc - start_cyc, 2);
            chk($sformatf("v%0d_no_read", i), first_read, -1);
         end else begin
            chk($sformatf("v%0d_read_latency", i), first_read - start_cyc, 2);
         end
         chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
         chk($sformatf("v%0d_abort_end", i), abort_f, 1'b0);
      end

      // Word credits: one 64-word burst fills the data FIFO.
      do_reset();
      rdv_allow = 0;
      pulse_start(32'h0, 256, 64, 8'h3C);
      wait_cycles(20);
      chk("wcred_one_burst", rec_addr.size(), 1);
      chk("wcred_read_idle", read, 1'b0);
      rdv_allow = 63;
      wait_cycles(80);
      chk("wcred_63_still_one", rec_addr.size(), 1);
      chk("wcred_63_read_idle", read, 1'b0);
      rdv_allow = 64;
      wait_cycles(10);
      chk("wcred_64_second", rec_addr.size(), 2);
      chk("wcred_second_addr", rec_addr[1], 32'h40);
      rdv_allow = BIG;
      wait_done(1, 2000, "wcred_done_timeout");
      chk("wcred_total_bursts", rec_addr.size(), 4);

      // Descriptor credits: compare block never pops.
      do_reset();
      pop_allow = 0;
      pulse_start(32'h500, 8, 1, 8'h11);
      wait_cycles(30);
      chk("dcred_four", rec_addr.size(), 4);
      pop_allow = 1;
      wait_cycles(10);
      chk("dcred_five", rec_addr.size(), 5);
      pop_allow = BIG;
      wait_done(1, 500, "dcred_done_timeout");
      chk("dcred_total", rec_addr.size(), 8);
      chk("dcred_last_addr", rec_addr[7], 32'h507);

      // Waitrequest stall on the first burst.
      do_reset();
      wr = 1'b1;
      pulse_start(32'h200, 4, 4, 8'h5A);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (read) found = 1'b1;
      end
      chk("wr_read_seen", found, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("wr_stall%0d_addr", k), address, 32'h200);
         chk($sformatf("wr_stall%0d_len", k), burstcount, 11'd4);
         chk($sformatf("wr_stall%0d_cmp_en", k), cmp_en, 1'b0);
      end
      @(posedge clk); #1;
      wr = 1'b0;
      @(negedge clk);
      chk("wr_accept_cmp_en", cmp_en, 1'b1);
      chk("wr_accept_cmp_addr", cmp_addr, 32'h200);
      chk("wr_accept_cmp_wc", cmp_wc, 10'd3);
      chk("wr_accept_cmp_ptrn", cmp_ptrn, 8'h5A);
      @(negedge clk);
      chk("wr_after_cmp_en", cmp_en, 1'b0);
      wait_done(1, 200, "wr_done_timeout");
      chk("wr_bursts", rec_addr.size(), 1);

      // Abort: four 8-word bursts in flight, 6 words still outstanding at error.
      do_reset();
      pop_allow = 0;
      rdv_allow = 26;
      pulse_start(32'h0, 48, 8, 8'hC3);
      wait_cycles(60);
      chk("abort_pre_bursts", rec_addr.size(), 4);
      chk("abort_pre_read", read, 1'b0);
      cmp_err = 1'b1;
      wait_cycles(5);
      chk("abort_wait_no_done", done_cnt, 0);
      chk("abort_wait_busy", busy, 1'b1);
      rdv_allow = 32;
      wait_done(1, 100, "abort_done_timeout");
      chk("abort_no_more_reads", rec_addr.size(), 4);
      chk("abort_done_after_last_rdv", done_cyc - last_rdv_cyc, 3);
      chk("abort_flag", abort_f, 1'b1);
      chk("abort_busy_end", busy, 1'b0);
      cmp_err = 1'b0;
      wait_cycles(10);
      chk("abort_sticky", abort_f, 1'b1);
      d0 = done_cnt;
      pulse_start(32'h0, 0, 4, 8'h00);
      chk("abort_cleared_by_start", abort_f, 1'b0);
      wait_cycles(5);
      chk("abort_restart_done", done_cnt, d0 + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
